// File: rtl/uart_rx_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cmd_decoder_if
// Description : Receiver byte stream in, register-file/ALU execution bus out.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_cmd_decoder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_par_err;
    logic                  rx_stp_err;
    logic                  cmd_ready;

    logic                  rf_wr_en;
    logic                  rf_rd_en;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_wr_data;
    logic                  opnd_wr_en;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  alu_en;
    logic [3:0]            alu_fun;
    logic                  frame_err;
    logic                  timeout_err;
    logic                  unknown_cmd;
    logic                  overrun_err;

    modport master (
        output rx_data, rx_valid, rx_par_err, rx_stp_err, cmd_ready,
        input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, opnd_wr_en,
               op_a, op_b, alu_en, alu_fun,
               frame_err, timeout_err, unknown_cmd, overrun_err
    );

    modport slave (
        input  rx_data, rx_valid, rx_par_err, rx_stp_err, cmd_ready,
        output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, opnd_wr_en,
               op_a, op_b, alu_en, alu_fun,
               frame_err, timeout_err, unknown_cmd, overrun_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cmd_decoder
// Description : Assembles UART command frames and issues RF/ALU strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cmd_decoder #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    TIMEOUT_CYC = 2816,
    parameter int                    CNT_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] CMD_RF_WR   = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] CMD_RF_RD   = 8'hBB,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD
) (
    input  wire logic               clk,
    input  wire logic               rst,
    uart_rx_cmd_decoder_if.slave    bus
);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_WR_ADDR = 3'd1;
    localparam logic [2:0] c_S_WR_DATA = 3'd2;
    localparam logic [2:0] c_S_RD_ADDR = 3'd3;
    localparam logic [2:0] c_S_OP_A    = 3'd4;
    localparam logic [2:0] c_S_OP_B    = 3'd5;
    localparam logic [2:0] c_S_FUN     = 3'd6;
    localparam logic [2:0] c_S_EXEC    = 3'd7;

    localparam logic [1:0] c_K_WR      = 2'd0;
    localparam logic [1:0] c_K_RD      = 2'd1;
    localparam logic [1:0] c_K_ALU_OP  = 2'd2;
    localparam logic [1:0] c_K_ALU_NOP = 2'd3;

    localparam bit               c_TO_EN    = (TIMEOUT_CYC != 0);
    localparam logic [CNT_WIDTH:0] c_TO_LIMIT =
        (TIMEOUT_CYC > 0) ? (CNT_WIDTH+1)'(TIMEOUT_CYC - 1) : '0;

    logic [2:0]            r_state, w_state_nxt;
    logic [1:0]            r_kind,  w_kind_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt,   w_cnt_nxt;
    logic [CNT_WIDTH:0]    w_cnt_inc;

    logic w_byte_ok, w_byte_bad, w_timeout;
    logic w_ld_addr, w_ld_wdata, w_ld_a, w_ld_b, w_ld_fun;
    logic w_wr_stb, w_rd_stb, w_opnd_stb, w_alu_stb;
    logic w_frame_err, w_timeout_err, w_unknown, w_overrun;

    logic                  r_rf_wr_en, r_rf_rd_en, r_opnd_wr_en, r_alu_en;
    logic [ADDR_WIDTH-1:0] r_rf_addr;
    logic [DATA_WIDTH-1:0] r_rf_wr_data, r_op_a, r_op_b;
    logic [3:0]            r_alu_fun;
    logic                  r_frame_err, r_timeout_err, r_unknown_cmd, r_overrun_err;

    assign w_byte_ok  = bus.rx_valid & ~(bus.rx_par_err | bus.rx_stp_err);
    assign w_byte_bad = bus.rx_valid &  (bus.rx_par_err | bus.rx_stp_err);
    assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
    // Abort fires on the idle cycle whose incremented count lands on the limit.
    assign w_timeout  = c_TO_EN && !bus.rx_valid && (w_cnt_inc >= c_TO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_kind  <= c_K_WR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_kind  <= w_kind_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_kind_nxt    = r_kind;
        w_cnt_nxt     = r_cnt;
        w_ld_addr     = 1'b0;
        w_ld_wdata    = 1'b0;
        w_ld_a        = 1'b0;
        w_ld_b        = 1'b0;
        w_ld_fun      = 1'b0;
        w_wr_stb      = 1'b0;
        w_rd_stb      = 1'b0;
        w_opnd_stb    = 1'b0;
        w_alu_stb     = 1'b0;
        w_frame_err   = 1'b0;
        w_timeout_err = 1'b0;
        w_unknown     = 1'b0;
        w_overrun     = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_byte_bad) begin
                    w_frame_err = 1'b1;
                end else if (w_byte_ok) begin
                    if (bus.rx_data == CMD_RF_WR) begin
                        w_state_nxt = c_S_WR_ADDR;
                        w_kind_nxt  = c_K_WR;
                    end else if (bus.rx_data == CMD_RF_RD) begin
                        w_state_nxt = c_S_RD_ADDR;
                        w_kind_nxt  = c_K_RD;
                    end else if (bus.rx_data == CMD_ALU_OP) begin
                        w_state_nxt = c_S_OP_A;
                        w_kind_nxt  = c_K_ALU_OP;
                    end else if (bus.rx_data == CMD_ALU_NOP) begin
                        w_state_nxt = c_S_FUN;
                        w_kind_nxt  = c_K_ALU_NOP;
                    end else begin
                        w_unknown = 1'b1;
                    end
                end
            end

            c_S_EXEC: begin
                w_cnt_nxt = '0;
                w_overrun = bus.rx_valid;
                if (bus.cmd_ready) begin
                    w_state_nxt = c_S_IDLE;
                    case (r_kind)
                        c_K_WR:      w_wr_stb = 1'b1;
                        c_K_RD:      w_rd_stb = 1'b1;
                        c_K_ALU_OP: begin
                            w_opnd_stb = 1'b1;
                            w_alu_stb  = 1'b1;
                        end
                        default:     w_alu_stb = 1'b1;
                    endcase
                end
            end

            default: begin
                if (w_byte_bad) begin
                    w_frame_err = 1'b1;
                    w_state_nxt = c_S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_byte_ok) begin
                    w_cnt_nxt = '0;
                    case (r_state)
                        c_S_WR_ADDR: begin
                            w_ld_addr   = 1'b1;
                            w_state_nxt = c_S_WR_DATA;
                        end
                        c_S_WR_DATA: begin
                            w_ld_wdata  = 1'b1;
                            w_state_nxt = c_S_EXEC;
                        end
                        c_S_RD_ADDR: begin
                            w_ld_addr   = 1'b1;
                            w_state_nxt = c_S_EXEC;
                        end
                        c_S_OP_A: begin
                            w_ld_a      = 1'b1;
                            w_state_nxt = c_S_OP_B;
                        end
                        c_S_OP_B: begin
                            w_ld_b      = 1'b1;
                            w_state_nxt = c_S_FUN;
                        end
                        default: begin
                            w_ld_fun    = 1'b1;
                            w_state_nxt = c_S_EXEC;
                        end
                    endcase
                end else if (w_timeout) begin
                    w_timeout_err = 1'b1;
                    w_state_nxt   = c_S_IDLE;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc[CNT_WIDTH-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wr_en    <= 1'b0;
            r_rf_rd_en    <= 1'b0;
            r_opnd_wr_en  <= 1'b0;
            r_alu_en      <= 1'b0;
            r_rf_addr     <= '0;
            r_rf_wr_data  <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_alu_fun     <= '0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_unknown_cmd <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_rf_wr_en    <= w_wr_stb;
            r_rf_rd_en    <= w_rd_stb;
            r_opnd_wr_en  <= w_opnd_stb;
            r_alu_en      <= w_alu_stb;
            r_frame_err   <= w_frame_err;
            r_timeout_err <= w_timeout_err;
            r_unknown_cmd <= w_unknown;
            r_overrun_err <= w_overrun;
            if (w_ld_addr)  r_rf_addr    <= bus.rx_data[ADDR_WIDTH-1:0];
            if (w_ld_wdata) r_rf_wr_data <= bus.rx_data;
            if (w_ld_a)     r_op_a       <= bus.rx_data;
            if (w_ld_b)     r_op_b       <= bus.rx_data;
            if (w_ld_fun)   r_alu_fun    <= bus.rx_data[3:0];
        end
    end

    assign bus.rf_wr_en    = r_rf_wr_en;
    assign bus.rf_rd_en    = r_rf_rd_en;
    assign bus.rf_addr     = r_rf_addr;
    assign bus.rf_wr_data  = r_rf_wr_data;
    assign bus.opnd_wr_en  = r_opnd_wr_en;
    assign bus.op_a        = r_op_a;
    assign bus.op_b        = r_op_b;
    assign bus.alu_en      = r_alu_en;
    assign bus.alu_fun     = r_alu_fun;
    assign bus.frame_err   = r_frame_err;
    assign bus.timeout_err = r_timeout_err;
    assign bus.unknown_cmd = r_unknown_cmd;
    assign bus.overrun_err = r_overrun_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_cmd_decoder
// Description : Directed scenarios plus randomized frames against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cmd_decoder;

    typedef struct {
        int         kind;   // 0 wr,1 rd,2 alu+opnd,3 alu,4 frame_err,5 unknown,6 timeout,7 overrun,8 bad
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] fun;
    } ev_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cnt_wr, cnt_rd, cnt_alu, cnt_ferr, cnt_terr, cnt_unk, cnt_ovr;
    bit   log_en;
    ev_t  obs_q[$];
    logic [7:0] ops [4];

    uart_rx_cmd_decoder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    uart_rx_cmd_decoder #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .TIMEOUT_CYC(16),
        .CNT_WIDTH  (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        ev_t e;
        if (bus.rf_wr_en)    cnt_wr++;
        if (bus.rf_rd_en)    cnt_rd++;
        if (bus.alu_en)      cnt_alu++;
        if (bus.frame_err)   cnt_ferr++;
        if (bus.timeout_err) cnt_terr++;
        if (bus.unknown_cmd) cnt_unk++;
        if (bus.overrun_err) cnt_ovr++;
        if (log_en && (bus.rf_wr_en || bus.rf_rd_en || bus.alu_en || bus.opnd_wr_en ||
                       bus.frame_err || bus.timeout_err || bus.unknown_cmd || bus.overrun_err)) begin
            if (bus.frame_err)                        e.kind = 4;
            else if (bus.unknown_cmd)                 e.kind = 5;
            else if (bus.timeout_err)                 e.kind = 6;
            else if (bus.overrun_err)                 e.kind = 7;
            else if (bus.rf_wr_en)                    e.kind = 0;
            else if (bus.rf_rd_en)                    e.kind = 1;
            else if (bus.opnd_wr_en && bus.alu_en)    e.kind = 2;
            else if (bus.alu_en && !bus.opnd_wr_en)   e.kind = 3;
            else                                      e.kind = 8;
            e.addr = bus.rf_addr;
            e.data = bus.rf_wr_data;
            e.a    = bus.op_a;
            e.b    = bus.op_b;
            e.fun  = bus.alu_fun;
            obs_q.push_back(e);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte for exactly one cycle; returns in the following cycle.
    task automatic send(input logic [7:0] b, input logic pe = 1'b0, input logic se = 1'b0);
        bus.rx_data    = b;
        bus.rx_valid   = 1'b1;
        bus.rx_par_err = pe;
        bus.rx_stp_err = se;
        step(1);
        bus.rx_valid   = 1'b0;
        bus.rx_par_err = 1'b0;
        bus.rx_stp_err = 1'b0;
        bus.rx_data    = 8'h00;
    endtask

    function automatic int flen(input logic [7:0] op);
        case (op)
            8'hAA:   return 3;
            8'hBB:   return 2;
            8'hCC:   return 4;
            8'hDD:   return 2;
            default: return 0;
        endcase
    endfunction

    task automatic test_reset();
        logic [60:0] outs;
        rst = 1'b1;
        step(2);
        outs = {bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wr_data, bus.opnd_wr_en,
                bus.op_a, bus.op_b, bus.alu_en, bus.alu_fun, bus.frame_err,
                bus.timeout_err, bus.unknown_cmd, bus.overrun_err};
        n_checks++;
        if (outs !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst = 1'b0;
        step(1);
        send(8'h77);
        n_checks++;
        if (bus.unknown_cmd !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_idle_unknown: got %b want 1", bus.unknown_cmd);
        end
    endtask

    task automatic test_rf_write();
        send(8'hAA); send(8'h05); send(8'h3C);
        n_checks++;
        if (bus.rf_wr_en !== 1'b0) begin
            n_errors++;
            $display("FAIL wr_early: got %b want 0", bus.rf_wr_en);
        end
        step(1);
        n_checks++;
        if (bus.rf_wr_en !== 1'b1 || bus.rf_addr !== 4'h5 || bus.rf_wr_data !== 8'h3C ||
            bus.rf_rd_en !== 1'b0 || bus.alu_en !== 1'b0) begin
            n_errors++;
            $display("FAIL wr_strobe: got wr=%b addr=%h data=%h rd=%b alu=%b want 1 5 3c 0 0",
                     bus.rf_wr_en, bus.rf_addr, bus.rf_wr_data, bus.rf_rd_en, bus.alu_en);
        end
        step(1);
        n_checks++;
        if (bus.rf_wr_en !== 1'b0) begin
            n_errors++;
            $display("FAIL wr_width: got %b want 0", bus.rf_wr_en);
        end
    endtask

    task automatic test_alu();
        send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
        step(1);
        n_checks++;
        if (bus.opnd_wr_en !== 1'b1 || bus.alu_en !== 1'b1 || bus.op_a !== 8'h12 ||
            bus.op_b !== 8'h34 || bus.alu_fun !== 4'h1) begin
            n_errors++;
            $display("FAIL alu_op: got opnd=%b alu=%b a=%h b=%h fun=%h want 1 1 12 34 1",
                     bus.opnd_wr_en, bus.alu_en, bus.op_a, bus.op_b, bus.alu_fun);
        end
        send(8'hDD); send(8'h07);
        step(1);
        n_checks++;
        if (bus.opnd_wr_en !== 1'b0 || bus.alu_en !== 1'b1 || bus.alu_fun !== 4'h7 ||
            bus.op_a !== 8'h12 || bus.op_b !== 8'h34) begin
            n_errors++;
            $display("FAIL alu_nop: got opnd=%b alu=%b fun=%h a=%h b=%h want 0 1 7 12 34",
                     bus.opnd_wr_en, bus.alu_en, bus.alu_fun, bus.op_a, bus.op_b);
        end
    endtask

    task automatic test_stall();
        int rd0, ovr0;
        bus.cmd_ready = 1'b0;
        send(8'hBB); send(8'h0A);
        rd0 = cnt_rd; ovr0 = cnt_ovr;
        step(5);
        send(8'h55);
        n_checks++;
        if (bus.overrun_err !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_overrun: got %b want 1", bus.overrun_err);
        end
        step(13);
        n_checks++;
        if (cnt_rd != rd0 || cnt_ovr - ovr0 != 1) begin
            n_errors++;
            $display("FAIL stall_quiet: got rd=%0d ovr=%0d want 0 1", cnt_rd - rd0, cnt_ovr - ovr0);
        end
        bus.cmd_ready = 1'b1;
        step(1);
        n_checks++;
        if (bus.rf_rd_en !== 1'b1 || bus.rf_addr !== 4'hA) begin
            n_errors++;
            $display("FAIL stall_release: got rd=%b addr=%h want 1 a", bus.rf_rd_en, bus.rf_addr);
        end
        step(1);
        n_checks++;
        if (bus.rf_rd_en !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_rd_width: got %b want 0", bus.rf_rd_en);
        end
    endtask

    task automatic test_errors();
        int w0;
        w0 = cnt_wr;
        send(8'hAA); send(8'h05, 1'b1, 1'b0);
        n_checks++;
        if (bus.frame_err !== 1'b1 || bus.rf_addr !== 4'hA) begin
            n_errors++;
            $display("FAIL err_midframe: got ferr=%b addr=%h want 1 a", bus.frame_err, bus.rf_addr);
        end
        step(3);
        n_checks++;
        if (cnt_wr != w0) begin
            n_errors++;
            $display("FAIL err_no_write: got %0d writes want 0", cnt_wr - w0);
        end
        send(8'h77);
        n_checks++;
        if (bus.unknown_cmd !== 1'b1) begin
            n_errors++;
            $display("FAIL err_unknown: got %b want 1", bus.unknown_cmd);
        end
        send(8'h42, 1'b0, 1'b1);
        n_checks++;
        if (bus.frame_err !== 1'b1 || bus.unknown_cmd !== 1'b0) begin
            n_errors++;
            $display("FAIL err_idle_stop: got ferr=%b unk=%b want 1 0", bus.frame_err, bus.unknown_cmd);
        end
        send(8'hAA); send(8'h01); send(8'hFF);
        step(1);
        n_checks++;
        if (bus.rf_wr_en !== 1'b1 || bus.rf_addr !== 4'h1 || bus.rf_wr_data !== 8'hFF) begin
            n_errors++;
            $display("FAIL err_recover: got wr=%b addr=%h data=%h want 1 1 ff",
                     bus.rf_wr_en, bus.rf_addr, bus.rf_wr_data);
        end
        send(8'hAA); send(8'hF3); send(8'h5A);
        step(1);
        n_checks++;
        if (bus.rf_wr_en !== 1'b1 || bus.rf_addr !== 4'h3 || bus.rf_wr_data !== 8'h5A ||
            bus.frame_err !== 1'b0) begin
            n_errors++;
            $display("FAIL addr_trunc: got wr=%b addr=%h data=%h ferr=%b want 1 3 5a 0",
                     bus.rf_wr_en, bus.rf_addr, bus.rf_wr_data, bus.frame_err);
        end
    endtask

    task automatic test_timeout();
        int t0;
        send(8'hCC);
        step(14);
        n_checks++;
        if (bus.timeout_err !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_early: got %b want 0", bus.timeout_err);
        end
        step(1);
        n_checks++;
        if (bus.timeout_err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_pulse: got %b want 1", bus.timeout_err);
        end
        step(1);
        n_checks++;
        if (bus.timeout_err !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_width: got %b want 0", bus.timeout_err);
        end
        send(8'h12);
        n_checks++;
        if (bus.unknown_cmd !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_idle: got %b want 1", bus.unknown_cmd);
        end
        t0 = cnt_terr;
        send(8'hCC);
        step(14);
        send(8'h56); send(8'h78); send(8'h09);
        step(1);
        n_checks++;
        if (bus.alu_en !== 1'b1 || bus.op_a !== 8'h56 || bus.op_b !== 8'h78 ||
            bus.alu_fun !== 4'h9 || cnt_terr != t0) begin
            n_errors++;
            $display("FAIL timeout_edge: got alu=%b a=%h b=%h fun=%h to=%0d want 1 56 78 9 0",
                     bus.alu_en, bus.op_a, bus.op_b, bus.alu_fun, cnt_terr - t0);
        end
    endtask

    task automatic test_reset_mid();
        logic [60:0] outs;
        int w0, r0;
        w0 = cnt_wr;
        send(8'hAA); send(8'h05);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        outs = {bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wr_data, bus.opnd_wr_en,
                bus.op_a, bus.op_b, bus.alu_en, bus.alu_fun, bus.frame_err,
                bus.timeout_err, bus.unknown_cmd, bus.overrun_err};
        n_checks++;
        if (outs !== '0) begin
            n_errors++;
            $display("FAIL rstmid_outputs: got %h want 0", outs);
        end
        send(8'h3C);
        n_checks++;
        if (bus.unknown_cmd !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_unknown: got %b want 1", bus.unknown_cmd);
        end
        step(2);
        n_checks++;
        if (cnt_wr != w0) begin
            n_errors++;
            $display("FAIL rstmid_no_write: got %0d want 0", cnt_wr - w0);
        end
        r0 = cnt_rd;
        bus.cmd_ready = 1'b0;
        send(8'hBB); send(8'h03);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.cmd_ready = 1'b1;
        step(3);
        n_checks++;
        if (cnt_rd != r0 || bus.rf_addr !== 4'h0) begin
            n_errors++;
            $display("FAIL rstexec: got rd=%0d addr=%h want 0 0", cnt_rd - r0, bus.rf_addr);
        end
    endtask

    task automatic test_back_to_back();
        int u0;
        bus.cmd_ready = 1'b1;
        send(8'hBB); send(8'h04); send(8'h99);
        n_checks++;
        if (bus.rf_rd_en !== 1'b1 || bus.overrun_err !== 1'b1 || bus.rf_addr !== 4'h4) begin
            n_errors++;
            $display("FAIL b2b_overrun: got rd=%b ovr=%b addr=%h want 1 1 4",
                     bus.rf_rd_en, bus.overrun_err, bus.rf_addr);
        end
        u0 = cnt_unk;
        step(2);
        n_checks++;
        if (cnt_unk != u0) begin
            n_errors++;
            $display("FAIL b2b_dropped: got %0d unknowns want 0", cnt_unk - u0);
        end
    endtask

    task automatic test_random();
        ev_t        exp_q[$];
        logic [7:0] frame[$];
        ev_t        e, o;
        logic [7:0] b, f0, f1, f2, f3;
        logic       pe, se, ok;
        int         r;
        bus.cmd_ready = 1'b1;
        obs_q.delete();
        log_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 99);
            b  = 8'($urandom);
            pe = 1'b0;
            se = 1'b0;
            if (frame.size() == 0 && r < 75) b = ops[$urandom_range(0, 3)];
            if (r >= 92) begin
                pe = 1'($urandom);
                se = ~pe | 1'($urandom);
            end
            e = '{kind: 0, addr: 4'h0, data: 8'h00, a: 8'h00, b: 8'h00, fun: 4'h0};
            if (pe | se) begin
                e.kind = 4;
                exp_q.push_back(e);
                frame.delete();
            end else if (frame.size() == 0) begin
                if (flen(b) == 0) begin
                    e.kind = 5;
                    exp_q.push_back(e);
                end else begin
                    frame.push_back(b);
                end
            end else begin
                frame.push_back(b);
                f0 = frame[0];
                if (frame.size() == flen(f0)) begin
                    f1 = frame[1];
                    f2 = (frame.size() > 2) ? frame[2] : 8'h00;
                    f3 = (frame.size() > 3) ? frame[3] : 8'h00;
                    case (f0)
                        8'hAA: begin e.kind = 0; e.addr = f1[3:0]; e.data = f2; end
                        8'hBB: begin e.kind = 1; e.addr = f1[3:0]; end
                        8'hCC: begin e.kind = 2; e.a = f1; e.b = f2; e.fun = f3[3:0]; end
                        default: begin e.kind = 3; e.fun = f1[3:0]; end
                    endcase
                    exp_q.push_back(e);
                    frame.delete();
                end
            end
            send(b, pe, se);
            step($urandom_range(1, 3));
        end
        step(3);
        log_en = 1'b0;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL rand_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            e  = exp_q[i];
            o  = obs_q[i];
            ok = (o.kind == e.kind);
            case (e.kind)
                0: ok = ok && (o.addr == e.addr) && (o.data == e.data);
                1: ok = ok && (o.addr == e.addr);
                2: ok = ok && (o.a == e.a) && (o.b == e.b) && (o.fun == e.fun);
                3: ok = ok && (o.fun == e.fun);
                default: ;
            endcase
            n_checks++;
            if (!ok) begin
                n_errors++;
                $display("FAIL rand_event %0d: got kind=%0d addr=%h data=%h a=%h b=%h fun=%h want kind=%0d addr=%h data=%h a=%h b=%h fun=%h",
                         i, o.kind, o.addr, o.data, o.a, o.b, o.fun,
                         e.kind, e.addr, e.data, e.a, e.b, e.fun);
            end
        end
        step(20);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cnt_wr = 0; cnt_rd = 0; cnt_alu = 0; cnt_ferr = 0;
        cnt_terr = 0; cnt_unk = 0; cnt_ovr = 0;
        log_en = 1'b0;
        ops[0] = 8'hAA; ops[1] = 8'hBB; ops[2] = 8'hCC; ops[3] = 8'hDD;
        rst            = 1'b1;
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus.rx_par_err = 1'b0;
        bus.rx_stp_err = 1'b0;
        bus.cmd_ready  = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_rf_write();
        test_alu();
        test_stall();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
